// File: rtl/dds9959_cmd_rx.sv
// AD9959 command receiver: decodes sequencer commands into SPI write frames
// followed by an IO_UPDATE pulse.
module dds9959_cmd_rx #(
    parameter logic [3:0] BOARD_IDX = 4'h0,
    parameter int         CLK_DIV   = 4,
    parameter int         IOUP_W    = 4
) (
    input  logic        wClk_i,
    input  logic        wReset_i,
    input  logic        wDDSTrig_i,
    input  logic [3:0]  wDDSBrdIdx_i,
    input  logic [36:0] wAD9959Cmd_i,
    output logic        wHWReady_o,
    output logic        rCsb_o,
    output logic        rSclk_o,
    output logic        rSdio_o,
    output logic        rIOUpdate_o,
    output logic [1:0]  rErr_o
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CSHOLD,
        IOUP
    } state_e;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] IOUP_LAST = 8'(IOUP_W - 1);

    state_e      state_q, state_d;
    logic [39:0] frame_q, frame_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic        sclk_q, sclk_d;
    logic [1:0]  err_q, err_d;
    logic        ready_q, ready_d;

    logic [4:0]  op;
    logic [31:0] pay;
    logic [39:0] new_frame;
    logic [5:0]  new_len;
    logic        op_ok;
    logic        hit;
    logic        div_end;
    logic        last_bit;

    assign op       = wAD9959Cmd_i[36:32];
    assign pay      = wAD9959Cmd_i[31:0];
    assign hit      = wDDSTrig_i && (wDDSBrdIdx_i == BOARD_IDX);
    assign div_end  = (div_q == DIV_LAST);
    assign last_bit = (bit_q == (len_q - 6'd1));

    // Frames are left-aligned so the MSB of any length sits at bit 39.
    always_comb begin
        new_frame = '0;
        new_len   = '0;
        op_ok     = 1'b1;
        unique case (1'b1)
            (op == 5'h1): begin
                new_frame = {8'h00, pay[3:0], 4'h0, 24'h0};
                new_len   = 6'd16;
            end
            (op == 5'h2): begin
                new_frame = {8'h04, pay};
                new_len   = 6'd40;
            end
            (op == 5'h3): begin
                new_frame = {8'h05, 2'b00, pay[13:0], 16'h0};
                new_len   = 6'd24;
            end
            (op == 5'h4): begin
                new_frame = {8'h06, 11'h0, 1'b1, 2'b00, pay[9:0], 8'h0};
                new_len   = 6'd32;
            end
            default: op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge wClk_i or negedge wReset_i) begin
        if (!wReset_i) begin
            state_q <= IDLE;
            frame_q <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            err_q   <= 2'b00;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit && op_ok) state_d = SHIFT;
            SHIFT:   if (div_end && sclk_q && last_bit) state_d = CSHOLD;
            CSHOLD:  if (div_end) state_d = IOUP;
            IOUP:    if (div_q == IOUP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_d = frame_q;
        len_d   = len_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        err_d   = err_q;
        err_d[1] = err_q[1] | (hit && (state_q == IDLE) && !op_ok);
        err_d[0] = err_q[0] | (hit && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (hit && op_ok) begin
                    frame_d = new_frame;
                    len_d   = new_len;
                    bit_d   = '0;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    if (sclk_q) begin
                        frame_d = {frame_q[38:0], 1'b0};
                        bit_d   = bit_q + 6'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            CSHOLD: div_d = div_end ? 8'd0 : div_q + 8'd1;
            IOUP:   div_d = (div_q == IOUP_LAST) ? 8'd0 : div_q + 8'd1;
            default: div_d = '0;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_comb begin
        wHWReady_o  = ready_q;
        rCsb_o      = (state_q != SHIFT);
        rSclk_o     = (state_q == SHIFT) && sclk_q;
        rSdio_o     = (state_q == SHIFT) && frame_q[39];
        rIOUpdate_o = (state_q == IOUP);
        rErr_o      = err_q;
    end

endmodule

// File: doc/dds9959_cmd_rx.md
DDS9959_CMD_RX -- requirements
Module: dds9959_cmd_rx

Interface
REQ-001 SHALL have parameter BOARD_IDX, default 4'h0: board index this instance responds to.
REQ-002 SHALL have parameter CLK_DIV, default 4, range 1..255: system-clock cycles per SCLK half-period.
REQ-003 SHALL have parameter IOUP_W, default 4, range 1..255: IO_UPDATE pulse width in clock cycles.
REQ-004 wClk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 wReset_i  in  1  reset; asynchronous assert, active-low.
REQ-006 wDDSTrig_i  in  1  one-cycle command strobe from the sequencer.
REQ-007 wDDSBrdIdx_i  in  4  target board index, qualified by wDDSTrig_i.
REQ-008 wAD9959Cmd_i  in  37  bits [36:32] opcode, [31:0] payload.
REQ-009 wHWReady_o  out  1  high = idle, able to accept a command.
REQ-010 rCsb_o  out  1  AD9959 chip select, active-low.
REQ-011 rSclk_o  out  1  AD9959 serial clock, idles low.
REQ-012 rSdio_o  out  1  AD9959 serial data, MSB first.
REQ-013 rIOUpdate_o  out  1  AD9959 IO_UPDATE pulse.
REQ-014 rErr_o  out  2  sticky flags: [0] overrun, [1] unsupported opcode.

Function
REQ-015 A command SHALL be accepted only when wDDSTrig_i=1, wDDSBrdIdx_i==BOARD_IDX, and state is IDLE; any other index, including 8..15 (AWG), is ignored with no state change.
REQ-016 On acceptance, opcode and payload SHALL be latched and the frame built as {instruction byte, data}, instruction byte = {1'b0 (write), 2'b00, addr[4:0]}.
REQ-017 Opcode mapping SHALL be: 5'h1 CH -> addr 0x00, 8-bit data {payload[3:0], 4'h0}; 5'h2 FRQ -> addr 0x04, data payload[31:0]; 5'h3 PH -> addr 0x05, data {2'b0, payload[13:0]}; 5'h4 AMP -> addr 0x06, data {11'b0, 1'b1, 2'b0, payload[9:0]}.
REQ-018 Frame length N SHALL be 16 (CH), 40 (FRQ), 24 (PH), 32 (AMP) bits.
REQ-019 Any other opcode SHALL set rErr_o[1], produce no SPI activity, and keep the block in IDLE (wHWReady_o stays 1).
REQ-020 States SHALL be IDLE, SHIFT, CSHOLD, IOUP; IDLE->SHIFT on acceptance; SHIFT->CSHOLD after bit N; CSHOLD->IOUP after CLK_DIV cycles; IOUP->IDLE after IOUP_W cycles.
REQ-021 wHWReady_o SHALL equal (state==IDLE), registered, so it is 0 starting the cycle after the accepting trigger edge.
REQ-022 In SHIFT, rCsb_o=0; each bit SHALL occupy 2*CLK_DIV cycles: first CLK_DIV cycles rSclk_o=0 with rSdio_o driven to the new bit, next CLK_DIV cycles rSclk_o=1 with rSdio_o held.
REQ-023 The first bit SHALL appear on rSdio_o in the first cycle of SHIFT, i.e. the cycle after the accepting edge.
REQ-024 In CSHOLD, rCsb_o=1, rSclk_o=0, rSdio_o=0.
REQ-025 In IOUP, rIOUpdate_o=1 for exactly IOUP_W cycles; otherwise 0.
REQ-026 Busy time (wHWReady_o=0) SHALL be exactly N*2*CLK_DIV + CLK_DIV + IOUP_W cycles.
REQ-027 A matching-index trigger while not IDLE SHALL be dropped and set rErr_o[0]; the in-flight frame is unaffected.
REQ-028 Bit and divider counters SHALL be wide enough for N=40 and CLK_DIV=255 without wrap.

Reset
REQ-029 While wReset_i=0, asynchronously: state IDLE, wHWReady_o=1, rCsb_o=1, rSclk_o=0, rSdio_o=0, rIOUpdate_o=0, rErr_o=2'b00, latched command cleared.
REQ-030 Reset mid-frame SHALL abort immediately with no IO_UPDATE; the first rising clock edge after release behaves as IDLE.
REQ-031 rErr_o SHALL clear only on reset.

Verification
REQ-032 CLK_DIV=2, IOUP_W=4, BOARD_IDX=0; trig, idx 0, cmd {5'h2, 32'h12345678} -> serial 0x04 then 0x12345678 MSB first; 40 SCLK rising edges; IO_UPDATE high 4 cycles; wHWReady_o low exactly 166 cycles.
REQ-033 Trig with cmd {5'h3, 32'hFFFF3FFF} -> stream 0x05, 0x3FFF; busy 24*4+2+4=102 cycles.
REQ-034 Trig with idx 1, then idx 9 -> no rCsb_o activity, wHWReady_o stays 1, rErr_o=00.
REQ-035 Trig opcode 5'h7 -> no SPI activity, rErr_o=2'b10, wHWReady_o stays 1.
REQ-036 Second matching trig 10 cycles into an AMP frame -> first frame completes bit-exact, rErr_o[0]=1, no second frame.
REQ-037 Assert wReset_i=0 at bit 20 of FRQ frame -> rCsb_o=1, rSclk_o=0 without waiting for a clock edge; no IO_UPDATE; next FRQ command after release transfers correctly.
